word_dispatch_rr: RTL and testbench

WORD_DISPATCH_RR -- requirements
Module: word_dispatch_rr

---
 rtl/word_dispatch_rr.sv | 187 ++++++++++++++++++
 tb/tb_word_dispatch_rr.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_dispatch_rr.sv
// word_dispatch_rr: moves one stored word at a time to a ready consumer unit,
// round-robin, then broadcasts the end-of-list marker once every unit is idle.
module word_dispatch_rr #(
    parameter  int N_UNITS      = 4,
    parameter  int WORD_MAX_LEN = 8,
    localparam int AW           = $clog2(WORD_MAX_LEN),
    localparam int LW           = $clog2(WORD_MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               src_empty,
    input  logic [7:0]         src_dout,
    output logic [AW-1:0]      src_rd_addr,
    input  logic [LW-1:0]      src_word_len,
    input  logic [15:0]        src_word_id,
    input  logic               src_word_list_end,
    output logic               src_set_empty,
    input  logic [N_UNITS-1:0] unit_ready,
    output logic [N_UNITS-1:0] unit_sel,
    output logic               unit_hdr_wr,
    output logic [15:0]        unit_word_id,
    output logic [LW-1:0]      unit_word_len,
    output logic               unit_wr_en,
    output logic [7:0]         unit_dout,
    output logic               unit_list_end,
    output logic               busy
);

    localparam int IW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_UNITS - 1);
    localparam logic [LW-1:0] MAX_LEN  = LW'(WORD_MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_HDR,
        S_XFER,
        S_RELEASE,
        S_END_WAIT,
        S_END_PULSE
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      last_grant_q;
    logic [AW-1:0]      rd_addr_q;
    logic [LW-1:0]      cnt_q;
    logic [N_UNITS-1:0] sel_q;
    logic               hdr_wr_q;
    logic               wr_en_q;
    logic               list_end_q;
    logic               set_empty_q;
    logic [15:0]        word_id_q;
    logic [LW-1:0]      word_len_q;

    logic [LW-1:0]      len_clamped;
    logic [LW-1:0]      last_byte;
    logic               addr_at_end;

    logic               grant_found;
    logic [IW-1:0]      grant_idx;
    logic [N_UNITS-1:0] grant_oh;
    int                 cand;
    logic [IW-1:0]      cand_idx;

    // Oversized lengths are truncated so the read address never wraps.
    assign len_clamped = (src_word_len > MAX_LEN) ? MAX_LEN : src_word_len;
    assign last_byte   = word_len_q - LW'(1);
    assign addr_at_end = (LW'(rd_addr_q) == last_byte);

    // Round-robin search starting just after the previously granted unit.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            cand = int'(last_grant_q) + 1 + k;
            if (cand >= N_UNITS) begin
                cand = cand - N_UNITS;
            end
            cand_idx = IW'(cand);
            if (!grant_found && unit_ready[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        grant_oh[grant_idx] = grant_found;
    end

    // Dispatch sequencer: state, grant history and every registered output.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_IDX;
            rd_addr_q    <= '0;
            cnt_q        <= '0;
            sel_q        <= '0;
            hdr_wr_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            list_end_q   <= 1'b0;
            set_empty_q  <= 1'b0;
            word_id_q    <= '0;
            word_len_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!src_empty) begin
                        state_q <= src_word_list_end ? S_END_WAIT : S_ARB;
                    end
                end
                S_ARB: begin
                    if (grant_found) begin
                        sel_q        <= grant_oh;
                        last_grant_q <= grant_idx;
                        hdr_wr_q     <= 1'b1;
                        word_id_q    <= src_word_id;
                        word_len_q   <= len_clamped;
                        rd_addr_q    <= '0;
                        state_q      <= S_HDR;
                    end
                end
                S_HDR: begin
                    hdr_wr_q <= 1'b0;
                    cnt_q    <= '0;
                    if (word_len_q != '0) begin
                        wr_en_q <= 1'b1;
                        if (!addr_at_end) begin
                            rd_addr_q <= rd_addr_q + AW'(1);
                        end
                        state_q <= S_XFER;
                    end else begin
                        sel_q       <= '0;
                        set_empty_q <= 1'b1;
                        state_q     <= S_RELEASE;
                    end
                end
                S_XFER: begin
                    if (cnt_q == last_byte) begin
                        wr_en_q     <= 1'b0;
                        sel_q       <= '0;
                        set_empty_q <= 1'b1;
                        state_q     <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + LW'(1);
                        if (!addr_at_end) begin
                            rd_addr_q <= rd_addr_q + AW'(1);
                        end
                    end
                end
                S_RELEASE: begin
                    set_empty_q <= 1'b0;
                    rd_addr_q   <= '0;
                    state_q     <= S_IDLE;
                end
                S_END_WAIT: begin
                    if (&unit_ready) begin
                        list_end_q  <= 1'b1;
                        set_empty_q <= 1'b1;
                        state_q     <= S_END_PULSE;
                    end
                end
                S_END_PULSE: begin
                    list_end_q   <= 1'b0;
                    set_empty_q  <= 1'b0;
                    last_grant_q <= LAST_IDX;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign src_rd_addr   = rd_addr_q;
    assign src_set_empty = set_empty_q;
    assign unit_sel      = sel_q;
    assign unit_hdr_wr   = hdr_wr_q;
    assign unit_word_id  = word_id_q;
    assign unit_word_len = word_len_q;
    assign unit_wr_en    = wr_en_q;
    assign unit_dout     = wr_en_q ? src_dout : 8'h00;
    assign unit_list_end = list_end_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_word_dispatch_rr.sv
// tb_word_dispatch_rr: directed vector table of whole-word transfers plus
// hand-written list-end and mid-word reset sequences.
module tb_word_dispatch_rr;

    localparam int N   = 4;
    localparam int WML = 8;
    localparam int AW  = 3;
    localparam int LW  = 4;

    logic          CLK = 1'b0;
    logic          rst;
    logic          src_empty;
    logic [7:0]    src_dout;
    logic [AW-1:0] src_rd_addr;
    logic [LW-1:0] src_word_len;
    logic [15:0]   src_word_id;
    logic          src_word_list_end;
    logic          src_set_empty;
    logic [N-1:0]  unit_ready;
    logic [N-1:0]  unit_sel;
    logic          unit_hdr_wr;
    logic [15:0]   unit_word_id;
    logic [LW-1:0] unit_word_len;
    logic          unit_wr_en;
    logic [7:0]    unit_dout;
    logic          unit_list_end;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [0:7];

    always #5 CLK = ~CLK;

    word_dispatch_rr #(.N_UNITS(N), .WORD_MAX_LEN(WML)) dut (
        .CLK(CLK),
        .rst(rst),
        .src_empty(src_empty),
        .src_dout(src_dout),
        .src_rd_addr(src_rd_addr),
        .src_word_len(src_word_len),
        .src_word_id(src_word_id),
        .src_word_list_end(src_word_list_end),
        .src_set_empty(src_set_empty),
        .unit_ready(unit_ready),
        .unit_sel(unit_sel),
        .unit_hdr_wr(unit_hdr_wr),
        .unit_word_id(unit_word_id),
        .unit_word_len(unit_word_len),
        .unit_wr_en(unit_wr_en),
        .unit_dout(unit_dout),
        .unit_list_end(unit_list_end),
        .busy(busy)
    );

    typedef struct {
        logic [3:0]  ready;
        int          stall;
        int          len;
        logic [15:0] id;
        logic [7:0]  base;
        int          unit;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: storage model reads synchronously and honours set_empty.
    task automatic tick();
        logic [AW-1:0] pa;
        logic pse;
        logic ok;
        pa  = src_rd_addr;
        pse = src_set_empty;
        @(posedge CLK);
        #1;
        src_dout = mem[pa];
        if (pse) src_empty = 1'b1;
        #1;
        ok = !((unit_hdr_wr & unit_wr_en) | (unit_hdr_wr & unit_list_end) |
               (unit_wr_en & unit_list_end));
        chk("strobe_mutex", 32'(ok), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_sel"}, 32'(unit_sel), 0);
        chk({tag, "_hdr"}, 32'(unit_hdr_wr), 0);
        chk({tag, "_wr"}, 32'(unit_wr_en), 0);
        chk({tag, "_le"}, 32'(unit_list_end), 0);
        chk({tag, "_setempty"}, 32'(src_set_empty), 0);
        chk({tag, "_addr"}, 32'(src_rd_addr), 0);
        chk({tag, "_dout"}, 32'(unit_dout), 0);
        chk({tag, "_id"}, 32'(unit_word_id), 0);
        chk({tag, "_len"}, 32'(unit_word_len), 0);
    endtask

    task automatic load_word(input int len, input logic [15:0] id,
                             input logic [7:0] base, input logic le);
        for (int i = 0; i < 8; i++) mem[i] = base + 8'(i);
        src_word_len      = LW'(len);
        src_word_id       = id;
        src_word_list_end = le;
        src_empty         = 1'b0;
    endtask

    // Starts with the DUT idle and a word present; follows it to release.
    task automatic expect_word(input logic [3:0] ready, input int stall,
                               input int len, input logic [15:0] id,
                               input logic [7:0] base, input int unit);
        int elen;
        int a;
        logic [3:0] oh;
        logic [7:0] eb;
        elen = (len > WML) ? WML : len;
        oh   = 4'(4'b0001 << unit);
        unit_ready = (stall > 0) ? 4'b0000 : ready;
        tick();
        for (int s = 0; s < stall; s++) begin
            chk("arbwait_busy", 32'(busy), 1);
            chk("arbwait_sel", 32'(unit_sel), 0);
            tick();
        end
        chk("arb_busy", 32'(busy), 1);
        chk("arb_sel", 32'(unit_sel), 0);
        chk("arb_hdr", 32'(unit_hdr_wr), 0);
        unit_ready = ready;
        tick();
        chk("hdr_strobe", 32'(unit_hdr_wr), 1);
        chk("hdr_sel", 32'(unit_sel), 32'(oh));
        chk("hdr_id", 32'(unit_word_id), 32'(id));
        chk("hdr_len", 32'(unit_word_len), 32'(elen));
        chk("hdr_addr", 32'(src_rd_addr), 0);
        chk("hdr_wr", 32'(unit_wr_en), 0);
        unit_ready = ~ready;
        for (int k = 0; k < elen; k++) begin
            tick();
            a  = (k + 1 < elen) ? k + 1 : elen - 1;
            eb = base + 8'(k);
            chk("byte_wr", 32'(unit_wr_en), 1);
            chk("byte_dout", 32'(unit_dout), 32'(eb));
            chk("byte_sel", 32'(unit_sel), 32'(oh));
            chk("byte_addr", 32'(src_rd_addr), 32'(a));
            chk("byte_setempty", 32'(src_set_empty), 0);
        end
        tick();
        chk("rel_setempty", 32'(src_set_empty), 1);
        chk("rel_sel", 32'(unit_sel), 0);
        chk("rel_wr", 32'(unit_wr_en), 0);
        chk("rel_busy", 32'(busy), 1);
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_setempty", 32'(src_set_empty), 0);
        chk("idle_released", 32'(src_empty), 1);
        unit_ready = ready;
    endtask

    initial begin
        tbl[0] = '{4'b1111, 0, 5,  16'd0,     8'h10, 0};
        tbl[1] = '{4'b1111, 0, 5,  16'd1,     8'h20, 1};
        tbl[2] = '{4'b1111, 0, 5,  16'd2,     8'h30, 2};
        tbl[3] = '{4'b1111, 0, 0,  16'd7,     8'h00, 3};
        tbl[4] = '{4'b1111, 0, 8,  16'd8,     8'h41, 0};
        tbl[5] = '{4'b1101, 0, 3,  16'd9,     8'h50, 2};
        tbl[6] = '{4'b0001, 2, 2,  16'd10,    8'h60, 0};
        tbl[7] = '{4'b1111, 0, 12, 16'd11,    8'h70, 1};
        tbl[8] = '{4'b0100, 0, 1,  16'hBEEF,  8'h80, 2};
        tbl[9] = '{4'b1000, 3, 4,  16'h1234,  8'h90, 3};

        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        rst               = 1'b1;
        src_empty         = 1'b1;
        src_dout          = 8'h00;
        src_word_len      = '0;
        src_word_id       = '0;
        src_word_list_end = 1'b0;
        unit_ready        = 4'b0000;
        tick();
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk("post_reset_busy", 32'(busy), 0);

        for (int v = 0; v < 10; v++) begin
            load_word(tbl[v].len, tbl[v].id, tbl[v].base, 1'b0);
            expect_word(tbl[v].ready, tbl[v].stall, tbl[v].len,
                        tbl[v].id, tbl[v].base, tbl[v].unit);
        end

        load_word(2, 16'h00AA, 8'hC0, 1'b0);
        expect_word(4'b1111, 0, 2, 16'h00AA, 8'hC0, 0);

        unit_ready = 4'b0111;
        load_word(0, 16'hFFFF, 8'h00, 1'b1);
        tick();
        chk("endwait_busy", 32'(busy), 1);
        chk("endwait_le", 32'(unit_list_end), 0);
        chk("endwait_setempty", 32'(src_set_empty), 0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("endwait_hold_le", 32'(unit_list_end), 0);
            chk("endwait_hold_busy", 32'(busy), 1);
        end
        unit_ready = 4'b1111;
        tick();
        chk("endpulse_le", 32'(unit_list_end), 1);
        chk("endpulse_setempty", 32'(src_set_empty), 1);
        chk("endpulse_sel", 32'(unit_sel), 0);
        tick();
        chk("endafter_le", 32'(unit_list_end), 0);
        chk("endafter_setempty", 32'(src_set_empty), 0);
        chk("endafter_busy", 32'(busy), 0);
        chk("endafter_released", 32'(src_empty), 1);
        src_word_list_end = 1'b0;

        load_word(3, 16'h00BB, 8'hD0, 1'b0);
        expect_word(4'b1111, 0, 3, 16'h00BB, 8'hD0, 0);

        load_word(6, 16'h0066, 8'hA0, 1'b0);
        unit_ready = 4'b1111;
        tick();
        tick();
        chk("abort_hdr_sel", 32'(unit_sel), 32'(4'b0010));
        for (int k = 0; k < 4; k++) tick();
        chk("abort_byte3_wr", 32'(unit_wr_en), 1);
        chk("abort_byte3_dout", 32'(unit_dout), 32'(8'hA3));
        rst = 1'b1;
        tick();
        chk_zero("abort");
        chk("abort_not_released", 32'(src_empty), 0);
        rst = 1'b0;
        expect_word(4'b1111, 0, 6, 16'h0066, 8'hA0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
